// File: rtl/present_pkg.sv
// present_pkg: shared constants, types and round helpers for the PRESENT-80 decrypt core.
//   BLOCK_W/KEY_W/ROUNDS fix the cipher geometry; RC_W is the round-counter width.
//   SBOX/SBOX_INV hold nibble i at bits [4i+3:4i].
package present_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 80;
    localparam int unsigned ROUNDS  = 31;
    localparam int unsigned RC_W    = $clog2(ROUNDS + 1);

    localparam logic [RC_W-1:0] RC_FIRST = RC_W'(1);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(ROUNDS);

    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {StIdle, StKeyExp, StDec, StDone} state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] sbox64_inv(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = sbox_inv(s[4*n +: 4]);
        end
        return r;
    endfunction

    // Bit j moves to bit 4j mod 63; bit 63 is fixed.
    function automatic logic [BLOCK_W-1:0] player_inv(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] p;
        int idx;
        p = '0;
        for (int j = 0; j < 63; j++) begin
            idx = (4 * j) % 63;
            p[idx[5:0]] = s[j];
        end
        p[63] = s[63];
        return p;
    endfunction

    // Rotate left 61, S-box on the top nibble, round counter into bits 19:15.
    function automatic logic [KEY_W-1:0] key_update_fwd(input logic [KEY_W-1:0] kr,
                                                        input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t          = {kr[18:0], kr[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_update_fwd for the same rc.
    function automatic logic [KEY_W-1:0] key_update_inv(input logic [KEY_W-1:0] kr,
                                                        input logic [RC_W-1:0]  rc);
        logic [KEY_W-1:0] t;
        t        = kr;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_decrypt_core_if.sv
// present_decrypt_core_if: ciphertext/key input and plaintext output handshakes.
//   master: producer of ciphertext/key and consumer of plaintext.
//   slave:  the decrypt core.
interface present_decrypt_core_if;
    import present_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] ciphertext;
    logic [KEY_W-1:0]   key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] plaintext;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext
    );

endinterface

// File: rtl/present_key_sched.sv
// present_key_sched: holds the running round-key register kr.
//   clk, reset (sync, active-low), load/load_key: overwrite kr,
//   step: replace kr by its update, dir: 0 forward / 1 inverse, rc: round counter,
//   key: the updated key that a step would write (forward or inverse of kr).
module present_key_sched
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [KEY_W-1:0] load_key,
    input  logic             step,
    input  logic             dir,
    input  logic [RC_W-1:0]  rc,
    output logic [KEY_W-1:0] key
);

    logic [KEY_W-1:0] kr_q;

    always_comb begin
        key = dir ? key_update_inv(kr_q, rc) : key_update_fwd(kr_q, rc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            kr_q <= '0;
        end else if (load) begin
            kr_q <= load_key;
        end else if (step) begin
            kr_q <= key;
        end
    end

endmodule

// File: rtl/present_decrypt_core.sv
// present_decrypt_core: iterative PRESENT-80 decryptor, one round per clock.
//   clk, reset (sync, active-low), bus: slave side of present_decrypt_core_if.
//   Handshake -> 31 forward key updates to K32 -> 31 inverse rounds -> plaintext held in DONE.
//   Optional PRESENT_KEY_CACHE_EN: remembers the last user key and its K32 so a repeated key
//   skips key expansion.
module present_decrypt_core
    import present_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    present_decrypt_core_if.slave  bus
);

    state_e             state_q, state_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [BLOCK_W-1:0] st_q, st_d;

    logic               ks_load, ks_step, ks_dir;
    logic [KEY_W-1:0]   ks_load_key, ks_key;
    logic               in_hs, out_hs;
    logic               cache_hit;
    logic [KEY_W-1:0]   cache_k32;

    // Gated by reset so in_ready stays low while reset is asserted.
    assign bus.in_ready  = reset && (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.plaintext = st_q;
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign out_hs        = bus.out_valid && bus.out_ready;

`ifdef PRESENT_KEY_CACHE_EN
    logic             cache_valid_q;
    logic [KEY_W-1:0] cache_key_q, cache_k32_q;

    assign cache_hit = cache_valid_q && (bus.key == cache_key_q);
    assign cache_k32 = cache_k32_q;

    // A miss invalidates the entry until its key expansion completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_k32_q   <= '0;
        end else begin
            if (in_hs && !cache_hit) begin
                cache_valid_q <= 1'b0;
                cache_key_q   <= bus.key;
            end
            if (state_q == StKeyExp && rc_q == RC_LAST) begin
                cache_valid_q <= 1'b1;
                cache_k32_q   <= ks_key;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_k32 = '0;
`endif

    present_key_sched u_key_sched (
        .clk      (clk),
        .reset    (reset),
        .load     (ks_load),
        .load_key (ks_load_key),
        .step     (ks_step),
        .dir      (ks_dir),
        .rc       (rc_q),
        .key      (ks_key)
    );

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        st_d        = st_q;
        ks_load     = 1'b0;
        ks_load_key = bus.key;
        ks_step     = 1'b0;
        ks_dir      = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_hs) begin
                    ks_load = 1'b1;
                    if (cache_hit) begin
                        st_d        = bus.ciphertext ^ cache_k32[KEY_W-1 -: BLOCK_W];
                        ks_load_key = cache_k32;
                        rc_d        = RC_LAST;
                        state_d     = StDec;
                    end else begin
                        st_d    = bus.ciphertext;
                        rc_d    = RC_FIRST;
                        state_d = StKeyExp;
                    end
                end
            end
            StKeyExp: begin
                ks_step = 1'b1;
                if (rc_q == RC_LAST) begin
                    // ks_key is K32 here: whitening with the last round key.
                    st_d    = st_q ^ ks_key[KEY_W-1 -: BLOCK_W];
                    state_d = StDec;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
            StDec: begin
                ks_step = 1'b1;
                ks_dir  = 1'b1;
                st_d    = sbox64_inv(player_inv(st_q)) ^ ks_key[KEY_W-1 -: BLOCK_W];
                rc_d    = rc_q - 1'b1;
                if (rc_q == RC_FIRST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            rc_q    <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            st_q    <= st_d;
        end
    end

endmodule

// File: tb/tb_present_decrypt_core.sv
// tb_present_decrypt_core: directed PRESENT-80 vectors plus random blocks whose ciphertext is
// produced by a forward-encryption reference model; checks plaintext, latency and handshakes.
// Build with PRESENT_KEY_CACHE_EN defined to expect the short latency on repeated keys.
module tb_present_decrypt_core;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    present_decrypt_core_if bus ();

    present_decrypt_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

`ifdef PRESENT_KEY_CACHE_EN
    bit          cache_ok  = 1'b0;
    logic [79:0] cache_key = '0;
`endif

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Forward PRESENT-80 encryption, straight from the cipher definition.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] k);
        logic [3:0]  sb [16];
        logic [79:0] rk [33];
        logic [79:0] t;
        logic [63:0] s, p;
        int          dst;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        rk[0] = '0;
        rk[1] = k;
        for (int i = 1; i < 32; i++) begin
            t          = {rk[i][18:0], rk[i][79:19]};
            t[79:76]   = sb[t[79:76]];
            t[19:15]   = t[19:15] ^ 5'(i);
            rk[i+1]    = t;
        end
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r][79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
            p = '0;
            for (int b = 0; b < 64; b++) begin
                dst = (b == 63) ? 63 : (b * 16) % 63;
                p[dst] = s[b];
            end
            s = p;
        end
        return s ^ rk[32][79:16];
    endfunction

    // One block: handshake, bounded wait for out_valid, optional hold, output handshake.
    task automatic run_block(input string tag, input logic [63:0] ct, input logic [79:0] k,
                             input logic [63:0] exp_pt, input int hold);
        int          n;
        int          lat;
        int          exp_lat;
        logic [95:0] junk;
        exp_lat = 62;
`ifdef PRESENT_KEY_CACHE_EN
        if (cache_ok && k == cache_key) exp_lat = 31;
`endif
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready idle"}, 80'(bus.in_ready), 80'd1);
        bus.in_valid   = 1'b1;
        bus.ciphertext = ct;
        bus.key        = k;
        bus.out_ready  = (hold == 0);
        @(negedge clk);
        check({tag, " in_ready busy"}, 80'(bus.in_ready), 80'd0);
        lat = 0;
        // Garbage on the input side while busy must be ignored.
        while (!bus.out_valid && lat < 200) begin
            junk           = {$urandom, $urandom, $urandom};
            bus.in_valid   = junk[0];
            bus.ciphertext = junk[63:0];
            bus.key        = junk[95:16];
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 80'(lat), 80'(exp_lat));
        check({tag, " plaintext"}, 80'(bus.plaintext), 80'(exp_pt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 80'(bus.out_valid), 80'd1);
            check({tag, " hold plaintext"}, 80'(bus.plaintext), 80'(exp_pt));
            check({tag, " hold in_ready"}, 80'(bus.in_ready), 80'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, " out_valid drop"}, 80'(bus.out_valid), 80'd0);
        check({tag, " in_ready back"}, 80'(bus.in_ready), 80'd1);
        bus.out_ready = 1'($urandom_range(0, 1));
`ifdef PRESENT_KEY_CACHE_EN
        if (lat == exp_lat) begin
            cache_ok  = 1'b1;
            cache_key = k;
        end
`endif
    endtask

    localparam logic [79:0] KEY_ONES = {80{1'b1}};
    localparam logic [63:0] BLK_ONES = {64{1'b1}};

    logic [63:0] pt;
    logic [79:0] k, last_k;
    logic [95:0] r;

    initial begin
        bus.in_valid   = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        bus.out_ready  = 1'b0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 80'(bus.in_ready), 80'd0);
        check("reset out_valid", 80'(bus.out_valid), 80'd0);
        check("reset plaintext", 80'(bus.plaintext), 80'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 80'(bus.in_ready), 80'd1);

        run_block("v1", 64'h5579C1387B228445, 80'h0, 64'h0, 0);
        run_block("v2", 64'hE72C46C0F5945049, KEY_ONES, 64'h0, 0);
        run_block("v3a", 64'hA112FFC72F68417B, 80'h0, BLK_ONES, 0);
        run_block("v3b", 64'h3333DCD3213210D2, KEY_ONES, BLK_ONES, 0);
        run_block("bp", 64'h5579C1387B228445, 80'h0, 64'h0, 10);
        run_block("v1 again", 64'h5579C1387B228445, 80'h0, 64'h0, 0);

        // Abort: reset low at edge 20 after the handshake of vector 2.
        bus.in_valid   = 1'b1;
        bus.ciphertext = 64'hE72C46C0F5945049;
        bus.key        = KEY_ONES;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort out_valid", 80'(bus.out_valid), 80'd0);
        check("abort in_ready low", 80'(bus.in_ready), 80'd0);
        reset = 1'b1;
`ifdef PRESENT_KEY_CACHE_EN
        cache_ok = 1'b0;
`endif
        @(negedge clk);
        check("abort in_ready", 80'(bus.in_ready), 80'd1);
        check("abort out_valid idle", 80'(bus.out_valid), 80'd0);
        run_block("after abort", 64'hA112FFC72F68417B, 80'h0, BLK_ONES, 0);

        last_k = '0;
        for (int i = 0; i < 8; i++) begin
            r  = {$urandom, $urandom, $urandom};
            pt = r[63:0];
            r  = {$urandom, $urandom, $urandom};
            if (i == 0 || $urandom_range(0, 2) != 0) k = r[79:0];
            else k = last_k;
            run_block("rnd", ref_encrypt(pt, k), k, pt, int'($urandom_range(0, 3)));
            last_k = k;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
